// File: rtl/bus_stall_ctrl.sv
// Pipeline sequencing controller for the 5-stage core.
// Arbitrates the shared memory bus between fetch (IF) and data access (MEM).
// It also merges bus-wait stalls with the ID/EX hazard stall requests and the
// exception flush into the stall[5:0] / flush controls of the pipeline registers.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | no bus transaction outstanding
// IF_BUSY  | instruction fetch outstanding on the bus
// MEM_BUSY | data load/store outstanding on the bus
// DRAIN    | flush arrived while busy; waiting out the ack, result dropped
module bus_stall_ctrl #(
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [DATA_W-1:0] if_addr,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [DATA_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [3:0]        mem_sel,
    input  logic              stallreq_from_id,
    input  logic              stallreq_from_ex,
    input  logic              flush_req,
    output logic              bus_req,
    output logic              bus_we,
    output logic [DATA_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [3:0]        bus_sel,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    output logic              mem_done,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              bus_err,
    output logic [5:0]        stall,
    output logic              flush
);

    typedef enum logic [1:0] {IDLE, IF_BUSY, MEM_BUSY, DRAIN} state_t;

    state_t     state, state_nxt;
    logic [7:0] wait_cnt;
    logic       flush_pending;
    logic       busy, timeout, finish, drain_end;
    logic       idle_flush, accept_mem, accept_if, if_wait;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state, arbitration, and combinational stall/flush merge.
    always_comb begin
        state_nxt  = state;
        stall      = 6'b000000;
        busy       = (state != IDLE);
        // The counter is 1 in the first bus_req cycle, so MAX_WAIT counts bus_req cycles.
        timeout    = busy && (wait_cnt == 8'(MAX_WAIT));
        finish     = busy && (bus_ack || timeout);
        // A flush arriving on the very cycle of the ack still drops the result.
        drain_end  = finish && ((state == DRAIN) || flush_req);
        // flush_pending is only ever set on the way back to IDLE.
        idle_flush = (state == IDLE) && (flush_req || flush_pending);
        // The done gating stops a stage that has not advanced yet from reissuing its request.
        accept_mem = (state == IDLE) && !idle_flush && mem_req && !mem_done;
        accept_if  = (state == IDLE) && !idle_flush && !accept_mem && if_req && !if_done;
        if_wait    = (state == IDLE) && if_req && !if_done;
        flush      = idle_flush;

        case (state)
            IDLE: begin
                if (accept_mem)     state_nxt = MEM_BUSY;
                else if (accept_if) state_nxt = IF_BUSY;
            end
            IF_BUSY, MEM_BUSY: begin
                if (finish)         state_nxt = IDLE;
                else if (flush_req) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (finish)         state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        if (state == DRAIN)                        stall = stall | 6'b111111;
        if ((state == MEM_BUSY) || accept_mem)     stall = stall | 6'b011111;
        if (stallreq_from_ex)                      stall = stall | 6'b001111;
        if (stallreq_from_id)                      stall = stall | 6'b000111;
        if ((state == IF_BUSY) || if_wait)         stall = stall | 6'b000011;
        if (idle_flush)                            stall = 6'b000000;
    end

    // Bus request registers, watchdog counter, result capture and done pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_req       <= 1'b0;
            bus_we        <= 1'b0;
            bus_addr      <= '0;
            bus_wdata     <= '0;
            bus_sel       <= 4'b0000;
            if_done       <= 1'b0;
            if_rdata      <= '0;
            mem_done      <= 1'b0;
            mem_rdata     <= '0;
            bus_err       <= 1'b0;
            wait_cnt      <= 8'd0;
            flush_pending <= 1'b0;
        end else begin
            if_done       <= 1'b0;
            mem_done      <= 1'b0;
            bus_err       <= 1'b0;
            flush_pending <= 1'b0;
            if (accept_mem) begin
                bus_req   <= 1'b1;
                bus_we    <= mem_we;
                bus_addr  <= mem_addr;
                bus_wdata <= mem_wdata;
                bus_sel   <= mem_sel;
                wait_cnt  <= 8'd1;
            end else if (accept_if) begin
                bus_req   <= 1'b1;
                bus_we    <= 1'b0;
                bus_addr  <= if_addr;
                bus_sel   <= 4'b1111;
                wait_cnt  <= 8'd1;
            end else if (finish) begin
                bus_req  <= 1'b0;
                wait_cnt <= 8'd0;
                // A hung slave is reported even when the result is being drained.
                bus_err  <= !bus_ack;
                if (drain_end) begin
                    flush_pending <= 1'b1;
                end else if (state == IF_BUSY) begin
                    if_done  <= 1'b1;
                    if_rdata <= bus_ack ? bus_rdata : '0;
                end else begin
                    mem_done <= 1'b1;
                    if (!bus_we) mem_rdata <= bus_ack ? bus_rdata : '0;
                end
            end else if (busy) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_bus_stall_ctrl.sv
// Self-checking bench for bus_stall_ctrl: directed cycle-by-cycle stimulus,
// done results checked against a queue of expected transfers.
module tb_bus_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, mem_req, mem_we, stallreq_from_id, stallreq_from_ex, flush_req;
    logic [31:0] if_addr, mem_addr, mem_wdata, bus_rdata;
    logic [3:0]  mem_sel;
    logic        bus_req, bus_we, bus_ack, if_done, mem_done, bus_err, flush;
    logic [31:0] bus_addr, bus_wdata, if_rdata, mem_rdata;
    logic [3:0]  bus_sel;
    logic [5:0]  stall;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        is_mem;
        logic [31:0] data;
        logic        err;
    } exp_t;
    exp_t exp_q[$];
    exp_t e;

    bus_stall_ctrl #(.DATA_W(32), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_sel(mem_sel),
        .stallreq_from_id(stallreq_from_id), .stallreq_from_ex(stallreq_from_ex),
        .flush_req(flush_req),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_sel(bus_sel),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .if_done(if_done), .if_rdata(if_rdata),
        .mem_done(mem_done), .mem_rdata(mem_rdata),
        .bus_err(bus_err), .stall(stall), .flush(flush)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to the next cycle and drive inputs just after the edge.
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Check the cycle's outputs mid-cycle.
    task automatic look(input string tag, input logic [5:0] st, input logic br, input logic fl);
        @(negedge clk);
        chk({tag, "_stall"}, 32'(stall), 32'(st));
        chk({tag, "_bus_req"}, 32'(bus_req), 32'(br));
        chk({tag, "_flush"}, 32'(flush), 32'(fl));
    endtask

    task automatic push(input logic is_mem, input logic [31:0] data, input logic err);
        exp_t x;
        x.is_mem = is_mem;
        x.data   = data;
        x.err    = err;
        exp_q.push_back(x);
    endtask

    // Scoreboard: every done pulse must match the oldest expected transfer.
    always @(negedge clk) begin
        if (if_done || mem_done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'({if_done, mem_done}), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("done_is_mem", 32'(mem_done), 32'(e.is_mem));
                chk("done_is_if", 32'(if_done), 32'(!e.is_mem));
                chk("done_rdata", e.is_mem ? mem_rdata : if_rdata, e.data);
                chk("done_bus_err", 32'(bus_err), 32'(e.err));
            end
        end else if (bus_err) begin
            chk("bus_err_without_done", 32'(bus_err), 32'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        rst = 1'b1; if_req = 0; mem_req = 0; mem_we = 0; stallreq_from_id = 0;
        stallreq_from_ex = 0; flush_req = 0; bus_ack = 0;
        if_addr = 0; mem_addr = 0; mem_wdata = 0; mem_sel = 0; bus_rdata = 0;
        next();
        next();
        look("reset", 6'b000000, 1'b0, 1'b0);
        chk("reset_if_done", 32'(if_done), 32'd0);
        chk("reset_mem_rdata", mem_rdata, 32'd0);

        // Fetch with ack in the third bus_req cycle.
        next();
        rst = 0; if_req = 1; if_addr = 32'h10;
        push(1'b0, 32'h3C011234, 1'b0);
        look("fetch_req", 6'b000011, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            next();
            if (i == 3) begin bus_ack = 1; bus_rdata = 32'h3C011234; end
            look("fetch_busy", 6'b000011, 1'b1, 1'b0);
            chk("fetch_addr", bus_addr, 32'h10);
            chk("fetch_sel", 32'(bus_sel), 32'hF);
            chk("fetch_we", 32'(bus_we), 32'd0);
        end
        next();
        bus_ack = 0;
        look("fetch_done", 6'b000000, 1'b0, 1'b0);
        chk("fetch_done_pulse", 32'(if_done), 32'd1);
        next();
        if_req = 0;
        look("fetch_after", 6'b000000, 1'b0, 1'b0);

        // Contention: MEM first, IF accepted in the mem_done cycle.
        next();
        if_req = 1; if_addr = 32'h20;
        mem_req = 1; mem_we = 0; mem_addr = 32'h80000004; mem_sel = 4'hF;
        push(1'b1, 32'hDEADBEEF, 1'b0);
        look("cont_req", 6'b011111, 1'b0, 1'b0);
        next();
        look("cont_mem1", 6'b011111, 1'b1, 1'b0);
        chk("cont_mem_addr", bus_addr, 32'h80000004);
        next();
        bus_ack = 1; bus_rdata = 32'hDEADBEEF;
        look("cont_mem2", 6'b011111, 1'b1, 1'b0);
        next();
        bus_ack = 0;
        push(1'b0, 32'h11112222, 1'b0);
        look("cont_memdone", 6'b000011, 1'b0, 1'b0);
        chk("cont_mem_done", 32'(mem_done), 32'd1);
        next();
        mem_req = 0;
        look("cont_if1", 6'b000011, 1'b1, 1'b0);
        chk("cont_if_addr", bus_addr, 32'h20);
        chk("cont_if_sel", 32'(bus_sel), 32'hF);
        next();
        bus_ack = 1; bus_rdata = 32'h11112222;
        look("cont_if2", 6'b000011, 1'b1, 1'b0);
        next();
        bus_ack = 0;
        look("cont_ifdone", 6'b000000, 1'b0, 1'b0);
        next();
        if_req = 0;

        // Flush during a store: drain, one flush cycle, no mem_done.
        next();
        mem_req = 1; mem_we = 1; mem_addr = 32'h100; mem_wdata = 32'hA5A5A5A5; mem_sel = 4'h3;
        look("fl_req", 6'b011111, 1'b0, 1'b0);
        next();
        flush_req = 1;
        look("fl_busy", 6'b011111, 1'b1, 1'b0);
        chk("fl_we", 32'(bus_we), 32'd1);
        chk("fl_wdata", bus_wdata, 32'hA5A5A5A5);
        chk("fl_sel", 32'(bus_sel), 32'h3);
        next();
        flush_req = 0; mem_req = 0;
        look("fl_drain1", 6'b111111, 1'b1, 1'b0);
        next();
        bus_ack = 1; bus_rdata = 32'h0BADF00D;
        look("fl_drain2", 6'b111111, 1'b1, 1'b0);
        next();
        bus_ack = 0;
        look("fl_flush", 6'b000000, 1'b0, 1'b1);
        next();
        look("fl_after", 6'b000000, 1'b0, 1'b0);
        chk("fl_mem_rdata_kept", mem_rdata, 32'hDEADBEEF);

        // Watchdog timeout on a load.
        next();
        mem_req = 1; mem_we = 0; mem_addr = 32'h200; mem_sel = 4'hF;
        push(1'b1, 32'h0, 1'b1);
        look("to_req", 6'b011111, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            next();
            look("to_busy", 6'b011111, 1'b1, 1'b0);
        end
        next();
        look("to_done", 6'b000000, 1'b0, 1'b0);
        chk("to_bus_err", 32'(bus_err), 32'd1);
        next();
        mem_req = 0;
        look("to_idle", 6'b000000, 1'b0, 1'b0);

        // Hazard merge in IDLE.
        next();
        stallreq_from_id = 1; stallreq_from_ex = 1;
        look("hz_both", 6'b001111, 1'b0, 1'b0);
        next();
        stallreq_from_ex = 0;
        look("hz_id", 6'b000111, 1'b0, 1'b0);
        next();
        stallreq_from_id = 0; stallreq_from_ex = 1;
        look("hz_ex", 6'b001111, 1'b0, 1'b0);
        next();
        stallreq_from_ex = 0; stallreq_from_id = 1; flush_req = 1;
        look("hz_flush", 6'b000000, 1'b0, 1'b1);
        next();
        stallreq_from_id = 0; flush_req = 0;
        look("hz_clear", 6'b000000, 1'b0, 1'b0);

        // Reset in the middle of a fetch.
        next();
        if_req = 1; if_addr = 32'h40;
        look("rs_req", 6'b000011, 1'b0, 1'b0);
        next();
        look("rs_busy", 6'b000011, 1'b1, 1'b0);
        next();
        rst = 1; if_req = 0;
        look("rs_assert", 6'b000011, 1'b1, 1'b0);
        next();
        rst = 0; bus_ack = 1; bus_rdata = 32'h77777777;
        look("rs_after", 6'b000000, 1'b0, 1'b0);
        next();
        bus_ack = 0;
        look("rs_late_ack", 6'b000000, 1'b0, 1'b0);
        chk("rs_if_rdata", if_rdata, 32'h0);
        next();
        look("rs_final", 6'b000000, 1'b0, 1'b0);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_stall_ctrl.md
Name: bus_stall_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage core.
- Arbitrates the single shared memory bus between instruction fetch (IF) and data access (MEM).
- Merges bus-wait stalls with ID/EX hazard stall requests and the exception flush request.
- Drives the stall[5:0] and flush inputs consumed by every pipeline register (pc, if_id, id_ex, ex_mem, mem_wb).

Parameters:
- DATA_W, 32, bus address/data width.
- MAX_WAIT, 255, watchdog limit in cycles for one bus transaction (1..255).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_req  in  1  IF stage requests instruction fetch
- if_addr  in  DATA_W  fetch address
- mem_req  in  1  MEM stage requests data access
- mem_we  in  1  data write enable
- mem_addr  in  DATA_W  data address
- mem_wdata  in  DATA_W  write data
- mem_sel  in  4  byte selects
- stallreq_from_id  in  1  ID hazard stall request
- stallreq_from_ex  in  1  EX multi-cycle stall request
- flush_req  in  1  exception flush request
- bus_req  out  1  bus transaction valid (registered)
- bus_we  out  1  bus write (registered)
- bus_addr  out  DATA_W  bus address (registered)
- bus_wdata  out  DATA_W  bus write data (registered)
- bus_sel  out  4  bus byte selects (registered; 4'b1111 for fetch)
- bus_ack  in  1  slave completion, 1-cycle pulse
- bus_rdata  in  DATA_W  slave read data, valid with bus_ack
- if_done  out  1  1-cycle pulse, fetch complete
- if_rdata  out  DATA_W  captured instruction
- mem_done  out  1  1-cycle pulse, data access complete
- mem_rdata  out  DATA_W  captured load data
- bus_err  out  1  1-cycle pulse, watchdog timeout
- stall  out  6  [0]=pc [1]=if [2]=id [3]=ex [4]=mem [5]=wb; 1=Stop
- flush  out  1  flush all pipeline registers

Behaviour:
- Reset (synchronous): state=IDLE; all outputs, counter and flush_pending are 0.
- Reset mid-transaction: bus_req drops at that edge; no done pulse, no flush.
- States:
  - IDLE: no transaction.
  - IF_BUSY / MEM_BUSY: transaction outstanding.
  - DRAIN: flush arrived while busy; waiting for the outstanding ack.
- Request gating: in IDLE, a request is accepted only if the matching done was 0 in the same cycle. The requesting stage has not yet advanced, so this prevents a reissue.
- IDLE arbitration:
  - flush_req=1: flush=1 combinationally this cycle, stall=0, requests ignored.
  - Otherwise mem_req has priority over if_req.
  - Accept: at the next edge, load bus_* and assert bus_req, then go to MEM_BUSY or IF_BUSY.
- Busy states:
  - bus_* held stable; wait counter increments each cycle.
  - On bus_ack: capture bus_rdata into if_rdata/mem_rdata, deassert bus_req, pulse if_done/mem_done next cycle, return to IDLE.
  - Latency: request cycle 0, bus_req cycle 1, ack cycle k, done and stall release cycle k+1.
- Watchdog: counter reaches MAX_WAIT with no ack -> terminate as if acked. Captured rdata=0, bus_err pulses together with done.
- flush_req while busy:
  - Go to DRAIN and keep the transaction until ack or timeout.
  - Then return to IDLE with flush=1 for exactly one cycle. Done pulse suppressed, rdata not updated.
  - Further flush_req during DRAIN is absorbed.
- stall is combinational: the OR of all active masks.
  - DRAIN: 111111.
  - MEM_BUSY, or mem_req being accepted this cycle: 011111.
  - stallreq_from_ex: 001111.
  - stallreq_from_id: 000111.
  - IF_BUSY, or if_req being accepted/waiting: 000011 (bubble into ID).
  - A cycle where flush=1: stall=000000.
- Simultaneous if_req and mem_req: MEM served first. IF is served in the IDLE cycle after mem_done (two idle-gap cycles minimum not required; IF accepted the cycle after mem_done).
- Writes: bus_we=1, and mem_done pulses on ack; mem_rdata is unchanged on writes.

Test Plan:
- Reset then fetch: if_req=1, if_addr=0x00000010, slave acks 3 cycles after bus_req, rdata=0x3C011234 -> bus_req high for 3 cycles with bus_addr=0x10, bus_sel=4'hF; stall=000011 throughout; if_done pulse with if_rdata=0x3C011234; stall=0 the same cycle.
- Contention: if_req and mem_req (load, 0x80000004) in the same IDLE cycle -> MEM issued first with stall=011111; after mem_done, IF issued next cycle with stall=000011.
- Flush while MEM_BUSY (store): flush_req pulse -> stall=111111 until ack; one flush=1 cycle after ack with stall=0; mem_done never pulses.
- Timeout: MAX_WAIT=4, no ack -> bus_req high 4 cycles, then bus_err and mem_done pulse together with mem_rdata=0; state IDLE.
- Hazard merge: IDLE, stallreq_from_id=1 and stallreq_from_ex=1 -> stall=001111; only id -> 000111; flush_req together with id -> flush=1, stall=000000.
- Reset mid-transaction: rst asserted while IF_BUSY -> next cycle bus_req=0, stall=0, no if_done; a late bus_ack is ignored.
